// File: rtl/sdr_arb_pkg.sv
// Shared types and default limits for the SDRAM channel-3 arbiter.
package sdr_arb_pkg;

  localparam int NV_STARVE_MAX_DEF = 4;
  localparam int TIMEOUT_DEF       = 255;

  typedef enum logic [1:0] {
    OWN_ROM,
    OWN_BG2,
    OWN_NV
  } owner_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_DONE
  } state_t;

endpackage

// File: rtl/ch3_watchdog.sv
// Wait-cycle counter for ch3: cleared on issue, counts while enabled,
// flags expiry on the TIMEOUT-th enabled cycle.
module ch3_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && !expired) begin
      count <= count + 1'b1;
    end
  end

  assign expired = en && (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/sdr_ch3_arbiter.sv
// SDRAM channel-3 arbiter: ROM writer, BG2 tile fetch and NVRAM port share
// one outstanding toggle-handshake access, with an NVRAM starvation guard.
module sdr_ch3_arbiter
  import sdr_arb_pkg::*;
#(
  parameter int AW            = 24,
  parameter int NV_STARVE_MAX = NV_STARVE_MAX_DEF,
  parameter int TIMEOUT       = TIMEOUT_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          rom_active,
  input  logic          rom_req,
  input  logic [AW-1:0] rom_addr,
  input  logic [15:0]   rom_din,
  input  logic [1:0]    rom_be,
  output logic          rom_rdy,
  input  logic          bg2_req,
  input  logic [AW-1:0] bg2_addr,
  output logic [15:0]   bg2_dout,
  output logic          bg2_rdy,
  input  logic          nv_req,
  input  logic          nv_we,
  input  logic [AW-1:0] nv_addr,
  input  logic [15:0]   nv_din,
  input  logic [1:0]    nv_be,
  output logic [15:0]   nv_dout,
  output logic          nv_rdy,
  input  logic          dbg_mask,
  output logic [AW-1:0] ch3_addr,
  output logic [15:0]   ch3_din,
  output logic [1:0]    ch3_be,
  output logic          ch3_rnw,
  output logic          ch3_req,
  input  logic [15:0]   ch3_dout,
  input  logic          ch3_ready,
  output logic          busy,
  output logic          timeout_err
);

  localparam logic [2:0] STARVE_LIM = 3'(NV_STARVE_MAX);

  state_t     state, state_nxt;
  owner_t     owner, grant_own;
  logic       grant_valid;
  logic       wd_clr, wd_en, wd_expired;
  logic [2:0] starve_cnt;

  assign wd_clr = (state == ST_ISSUE);
  assign wd_en  = (state == ST_WAIT);
  assign busy   = (state != ST_IDLE);

  ch3_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .clr     (wd_clr),
    .en      (wd_en),
    .expired (wd_expired)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no branch can
    // leave a value unassigned and infer a latch.
    state_nxt   = state;
    grant_valid = 1'b0;
    grant_own   = OWN_ROM;
    case (state)
      ST_IDLE: begin
        // During a download only the ROM writer may touch ch3.
        if (rom_active) begin
          grant_valid = rom_req;
          grant_own   = OWN_ROM;
        end else if (nv_req && (starve_cnt == STARVE_LIM)) begin
          grant_valid = 1'b1;
          grant_own   = OWN_NV;
        end else if (bg2_req && !dbg_mask) begin
          grant_valid = 1'b1;
          grant_own   = OWN_BG2;
        end else if (nv_req) begin
          grant_valid = 1'b1;
          grant_own   = OWN_NV;
        end
        if (grant_valid) state_nxt = ST_ISSUE;
      end
      ST_ISSUE: state_nxt = ST_WAIT;
      ST_WAIT:  if (ch3_ready || wd_expired) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner       <= OWN_ROM;
      ch3_addr    <= '0;
      ch3_din     <= '0;
      ch3_be      <= 2'b11;
      ch3_rnw     <= 1'b1;
      ch3_req     <= 1'b0;
      bg2_dout    <= '0;
      nv_dout     <= '0;
      rom_rdy     <= 1'b0;
      bg2_rdy     <= 1'b0;
      nv_rdy      <= 1'b0;
      timeout_err <= 1'b0;
      starve_cnt  <= '0;
    end else begin
      rom_rdy <= 1'b0;
      bg2_rdy <= 1'b0;
      nv_rdy  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (grant_valid && grant_own == OWN_NV) begin
            starve_cnt <= '0;
          end else if (!nv_req) begin
            starve_cnt <= '0;
          end else if (grant_valid && grant_own == OWN_BG2 && starve_cnt < STARVE_LIM) begin
            starve_cnt <= starve_cnt + 1'b1;
          end
          if (grant_valid) begin
            owner <= grant_own;
            case (grant_own)
              OWN_ROM: begin
                ch3_addr <= rom_addr;
                ch3_din  <= rom_din;
                ch3_be   <= rom_be;
                ch3_rnw  <= 1'b0;
              end
              OWN_BG2: begin
                ch3_addr <= bg2_addr;
                ch3_be   <= 2'b11;
                ch3_rnw  <= 1'b1;
              end
              default: begin
                ch3_addr <= nv_addr;
                ch3_din  <= nv_din;
                ch3_be   <= nv_be;
                ch3_rnw  <= !nv_we;
              end
            endcase
          end
        end
        ST_ISSUE: ch3_req <= ~ch3_req;
        ST_WAIT: begin
          if (ch3_ready || wd_expired) begin
            // A timed-out access leaves dout untouched but still completes.
            if (!ch3_ready) begin
              timeout_err <= 1'b1;
            end else if (owner == OWN_BG2) begin
              bg2_dout <= ch3_dout;
            end else if (owner == OWN_NV) begin
              nv_dout <= ch3_dout;
            end
            case (owner)
              OWN_ROM: rom_rdy <= 1'b1;
              OWN_BG2: bg2_rdy <= 1'b1;
              default: nv_rdy  <= 1'b1;
            endcase
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sdr_ch3_arbiter.sv
// Randomized self-checking bench for sdr_ch3_arbiter: the bench plays the
// three requesters and the SDRAM side, and predicts grants from priority rules.
module tb_sdr_ch3_arbiter;

  localparam int AW     = 24;
  localparam int STARVE = 4;
  localparam int TMO    = 255;

  logic          clk = 1'b0;
  logic          reset;
  logic          rom_active, rom_req;
  logic [AW-1:0] rom_addr;
  logic [15:0]   rom_din;
  logic [1:0]    rom_be;
  logic          rom_rdy;
  logic          bg2_req;
  logic [AW-1:0] bg2_addr;
  logic [15:0]   bg2_dout;
  logic          bg2_rdy;
  logic          nv_req, nv_we;
  logic [AW-1:0] nv_addr;
  logic [15:0]   nv_din;
  logic [1:0]    nv_be;
  logic [15:0]   nv_dout;
  logic          nv_rdy;
  logic          dbg_mask;
  logic [AW-1:0] ch3_addr;
  logic [15:0]   ch3_din;
  logic [1:0]    ch3_be;
  logic          ch3_rnw, ch3_req;
  logic [15:0]   ch3_dout;
  logic          ch3_ready;
  logic          busy, timeout_err;

  int checks   = 0;
  int failures = 0;

  logic          last_req;
  logic [AW-1:0] obs_addr;
  logic [15:0]   obs_din;
  logic [1:0]    obs_be;
  logic          obs_rnw;
  logic [15:0]   m_bg2_dout, m_nv_dout;

  sdr_ch3_arbiter #(
    .AW            (AW),
    .NV_STARVE_MAX (STARVE),
    .TIMEOUT       (TMO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .rom_active  (rom_active),
    .rom_req     (rom_req),
    .rom_addr    (rom_addr),
    .rom_din     (rom_din),
    .rom_be      (rom_be),
    .rom_rdy     (rom_rdy),
    .bg2_req     (bg2_req),
    .bg2_addr    (bg2_addr),
    .bg2_dout    (bg2_dout),
    .bg2_rdy     (bg2_rdy),
    .nv_req      (nv_req),
    .nv_we       (nv_we),
    .nv_addr     (nv_addr),
    .nv_din      (nv_din),
    .nv_be       (nv_be),
    .nv_dout     (nv_dout),
    .nv_rdy      (nv_rdy),
    .dbg_mask    (dbg_mask),
    .ch3_addr    (ch3_addr),
    .ch3_din     (ch3_din),
    .ch3_be      (ch3_be),
    .ch3_rnw     (ch3_rnw),
    .ch3_req     (ch3_req),
    .ch3_dout    (ch3_dout),
    .ch3_ready   (ch3_ready),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  // Reference rules: owner code 0=ROM, 1=BG2, 2=NV, -1=nobody eligible.
  function automatic int predict(bit ra, bit rr, bit br, bit nr, bit msk, int s);
    if (ra) return rr ? 0 : -1;
    if (nr && s == STARVE) return 2;
    if (br && !msk) return 1;
    if (nr) return 2;
    return -1;
  endfunction

  function automatic int next_starve(int own, bit nr, int s);
    if (own == 2 || !nr) return 0;
    if (own == 1) return (s + 1 > STARVE) ? STARVE : s + 1;
    return s;
  endfunction

  task automatic drive_idle();
    rom_active = 0; rom_req = 0; rom_addr = '0; rom_din = '0; rom_be = 2'b11;
    bg2_req = 0; bg2_addr = '0;
    nv_req = 0; nv_we = 0; nv_addr = '0; nv_din = '0; nv_be = 2'b11;
    dbg_mask = 0; ch3_dout = '0; ch3_ready = 0;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    drive_idle();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    last_req = 1'b0;
    m_bg2_dout = '0;
    m_nv_dout = '0;
    @(negedge clk);
  endtask

  task automatic wait_toggle(input int limit, output int lat, output bit ok);
    ok = 0;
    lat = 0;
    for (int i = 1; i <= limit; i++) begin
      @(negedge clk);
      if (ch3_req !== last_req) begin
        last_req = ch3_req;
        lat = i;
        ok = 1;
        obs_addr = ch3_addr;
        obs_din = ch3_din;
        obs_be = ch3_be;
        obs_rnw = ch3_rnw;
        break;
      end
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL ch3_toggle: no ch3_req edge within %0d cycles", limit);
    end
  endtask

  task automatic pulse_ready(input logic [15:0] d);
    ch3_dout = d;
    ch3_ready = 1'b1;
    @(negedge clk);
    ch3_ready = 1'b0;
  endtask

  // Waits for an access, answers after lat cycles, returns whose rdy fired.
  task automatic serve(input int lat, input logic [15:0] d, output int own);
    int  l;
    bit  ok;
    own = -1;
    wait_toggle(10, l, ok);
    if (!ok) return;
    repeat (lat) @(negedge clk);
    pulse_ready(d);
    case ({rom_rdy, bg2_rdy, nv_rdy})
      3'b100:  own = 0;
      3'b010:  own = 1;
      3'b001:  own = 2;
      3'b000:  own = -1;
      default: own = -2;
    endcase
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive_idle();
    repeat (2) @(negedge clk);
    checks++;
    if ({ch3_req, ch3_rnw, ch3_be, busy, timeout_err, rom_rdy, bg2_rdy, nv_rdy} !== 9'b0_1_11_0_0_0_0_0) begin
      failures++;
      $display("FAIL reset_ctrl: got=%b exp=%b",
               {ch3_req, ch3_rnw, ch3_be, busy, timeout_err, rom_rdy, bg2_rdy, nv_rdy}, 9'b0_1_11_0_0_0_0_0);
    end
    checks++;
    if (ch3_addr !== '0 || ch3_din !== '0 || bg2_dout !== '0 || nv_dout !== '0) begin
      failures++;
      $display("FAIL reset_data: addr=%h din=%h bg2_dout=%h nv_dout=%h exp all zero",
               ch3_addr, ch3_din, bg2_dout, nv_dout);
    end
    apply_reset();
    checks++;
    if (busy !== 1'b0 || ch3_req !== 1'b0) begin
      failures++;
      $display("FAIL reset_release: busy=%b ch3_req=%b exp 0 0", busy, ch3_req);
    end
  endtask

  task automatic test_rom_write();
    int lat, n_rom, n_other;
    bit ok;
    rom_active = 1; rom_addr = 24'h000100; rom_din = 16'hA55A; rom_be = 2'b11; rom_req = 1;
    wait_toggle(10, lat, ok);
    checks++;
    if (lat != 2) begin
      failures++;
      $display("FAIL rom_issue_latency: got=%0d exp=2", lat);
    end
    checks++;
    if (obs_rnw !== 1'b0 || obs_addr !== 24'h000100 || obs_din !== 16'hA55A || obs_be !== 2'b11 || busy !== 1'b1) begin
      failures++;
      $display("FAIL rom_fields: rnw=%b addr=%h din=%h be=%b busy=%b exp 0 000100 a55a 11 1",
               obs_rnw, obs_addr, obs_din, obs_be, busy);
    end
    repeat (2) @(negedge clk);
    pulse_ready(16'hDEAD);
    n_rom = 0;
    n_other = 0;
    for (int i = 0; i < 8; i++) begin
      if (rom_rdy) begin n_rom++; rom_req = 0; end
      if (bg2_rdy || nv_rdy) n_other++;
      @(negedge clk);
    end
    checks++;
    if (n_rom != 1 || n_other != 0) begin
      failures++;
      $display("FAIL rom_rdy_count: rom=%0d other=%0d exp 1 0", n_rom, n_other);
    end
    checks++;
    if (bg2_dout !== m_bg2_dout || nv_dout !== m_nv_dout) begin
      failures++;
      $display("FAIL rom_dout_untouched: bg2=%h nv=%h exp %h %h", bg2_dout, nv_dout, m_bg2_dout, m_nv_dout);
    end
  endtask

  task automatic test_bg2_under_download();
    bit toggled;
    int own;
    rom_active = 1; rom_req = 0; bg2_addr = 24'(($urandom));; bg2_req = 1;
    toggled = 0;
    repeat (50) begin
      @(negedge clk);
      if (ch3_req !== last_req) toggled = 1;
    end
    checks++;
    if (toggled) begin
      failures++;
      $display("FAIL bg2_held_off: ch3 toggled during download exp none");
    end
    rom_active = 0;
    serve(1, 16'h1234, own);
    checks++;
    if (own != 1 || obs_rnw !== 1'b1 || obs_addr !== bg2_addr) begin
      failures++;
      $display("FAIL bg2_grant: owner=%0d rnw=%b addr=%h exp 1 1 %h", own, obs_rnw, obs_addr, bg2_addr);
    end
    checks++;
    if (bg2_dout !== 16'h1234) begin
      failures++;
      $display("FAIL bg2_dout: got=%h exp=1234", bg2_dout);
    end
    m_bg2_dout = 16'h1234;
    bg2_req = 0;
    @(negedge clk);
    checks++;
    if (bg2_rdy !== 1'b0) begin
      failures++;
      $display("FAIL bg2_rdy_width: got=%b exp=0", bg2_rdy);
    end
  endtask

  task automatic test_starvation();
    int s, exp_own, own;
    logic [15:0] d;
    apply_reset();
    s = 0;
    bg2_addr = 24'h0B0B0B; nv_addr = 24'h0C0C0C; nv_we = 0;
    bg2_req = 1; nv_req = 1;
    for (int i = 0; i < 10; i++) begin
      exp_own = predict(0, 0, 1, 1, 0, s);
      d = 16'($urandom);
      serve(int'($urandom % 3), d, own);
      checks++;
      if (own != exp_own) begin
        failures++;
        $display("FAIL starve_grant[%0d]: owner=%0d exp=%0d", i, own, exp_own);
      end
      s = next_starve(exp_own, 1, s);
      if (i == 9) begin
        bg2_req = 0;
        nv_req = 0;
      end
    end
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL starve_drain: busy=%b exp=0", busy);
    end
  endtask

  task automatic test_dbg_mask();
    bit toggled;
    int own;
    logic [15:0] d;
    dbg_mask = 1; bg2_req = 1; nv_req = 1; nv_we = 1;
    nv_addr = 24'($urandom); nv_din = 16'($urandom); nv_be = 2'b01;
    d = 16'($urandom);
    serve(0, d, own);
    checks++;
    if (own != 2 || obs_rnw !== 1'b0 || obs_din !== nv_din || obs_be !== 2'b01 || obs_addr !== nv_addr) begin
      failures++;
      $display("FAIL mask_nv_first: owner=%0d rnw=%b din=%h be=%b exp 2 0 %h 01", own, obs_rnw, obs_din, obs_be, nv_din);
    end
    m_nv_dout = d;
    nv_req = 0;
    toggled = 0;
    repeat (20) begin
      @(negedge clk);
      if (ch3_req !== last_req) toggled = 1;
    end
    checks++;
    if (toggled) begin
      failures++;
      $display("FAIL mask_blocks_bg2: ch3 toggled while masked exp none");
    end
    dbg_mask = 0;
    d = 16'($urandom);
    serve(0, d, own);
    checks++;
    if (own != 1 || bg2_dout !== d) begin
      failures++;
      $display("FAIL mask_release: owner=%0d dout=%h exp 1 %h", own, bg2_dout, d);
    end
    m_bg2_dout = d;
    bg2_req = 0;
    @(negedge clk);
  endtask

  task automatic test_timeout();
    int lat, n, own;
    bit ok, early;
    logic [15:0] d;
    nv_we = 0; nv_addr = 24'($urandom); nv_req = 1;
    wait_toggle(10, lat, ok);
    n = 0;
    early = 0;
    for (int i = 1; i <= 400; i++) begin
      @(negedge clk);
      if (i == 200 && timeout_err !== 1'b0) early = 1;
      if (nv_rdy) begin
        n = i;
        break;
      end
    end
    checks++;
    if (early) begin
      failures++;
      $display("FAIL timeout_early: timeout_err set before 200 wait cycles");
    end
    checks++;
    if (n < TMO || n > TMO + 1) begin
      failures++;
      $display("FAIL timeout_rdy_at: got=%0d exp=%0d..%0d (0 = never)", n, TMO, TMO + 1);
    end
    checks++;
    if (timeout_err !== 1'b1 || nv_dout !== m_nv_dout) begin
      failures++;
      $display("FAIL timeout_state: err=%b nv_dout=%h exp 1 %h", timeout_err, nv_dout, m_nv_dout);
    end
    nv_req = 0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || nv_rdy !== 1'b0) begin
      failures++;
      $display("FAIL timeout_idle: busy=%b nv_rdy=%b exp 0 0", busy, nv_rdy);
    end
    bg2_addr = 24'($urandom); bg2_req = 1;
    d = 16'($urandom);
    serve(2, d, own);
    checks++;
    if (own != 1 || bg2_dout !== d || timeout_err !== 1'b1) begin
      failures++;
      $display("FAIL timeout_recover: owner=%0d dout=%h err=%b exp 1 %h 1", own, bg2_dout, timeout_err, d);
    end
    m_bg2_dout = d;
    bg2_req = 0;
    @(negedge clk);
  endtask

  task automatic test_reset_in_wait();
    int lat, n;
    bit ok;
    bg2_addr = 24'($urandom); bg2_req = 1;
    wait_toggle(10, lat, ok);
    @(negedge clk);
    reset = 1'b1;
    bg2_req = 0;
    @(negedge clk);
    reset = 1'b0;
    last_req = 1'b0;
    m_bg2_dout = '0;
    m_nv_dout = '0;
    pulse_ready(16'hBEEF);
    n = 0;
    for (int i = 0; i < 5; i++) begin
      if (rom_rdy || bg2_rdy || nv_rdy) n++;
      @(negedge clk);
    end
    checks++;
    if (n != 0 || busy !== 1'b0 || ch3_req !== 1'b0 || bg2_dout !== 16'h0000) begin
      failures++;
      $display("FAIL reset_in_wait: rdys=%0d busy=%b ch3_req=%b bg2_dout=%h exp 0 0 0 0000",
               n, busy, ch3_req, bg2_dout);
    end
  endtask

  task automatic test_random();
    int s, exp_own, own;
    bit ra, rr, br, nr, msk, ernw;
    logic [AW-1:0] ea;
    logic [15:0] edin, d;
    logic [1:0] ebe;
    apply_reset();
    s = 0;
    for (int r = 0; r < 40; r++) begin
      do begin
        ra = ($urandom % 4) == 0;
        rr = 1'($urandom);
        br = 1'($urandom);
        nr = 1'($urandom);
        msk = ($urandom % 4) == 0;
        exp_own = predict(ra, rr, br, nr, msk, s);
      end while (exp_own < 0);
      rom_active = ra; rom_req = rr; bg2_req = br; nv_req = nr; dbg_mask = msk;
      rom_addr = 24'($urandom); rom_din = 16'($urandom); rom_be = 2'($urandom);
      bg2_addr = 24'($urandom);
      nv_addr = 24'($urandom); nv_din = 16'($urandom); nv_be = 2'($urandom); nv_we = 1'($urandom);
      case (exp_own)
        0:       begin ea = rom_addr; ernw = 0;      edin = rom_din; ebe = rom_be; end
        1:       begin ea = bg2_addr; ernw = 1;      edin = '0;      ebe = 2'b11;  end
        default: begin ea = nv_addr;  ernw = !nv_we; edin = nv_din;  ebe = nv_be;  end
      endcase
      d = 16'($urandom);
      serve(int'($urandom % 5), d, own);
      checks++;
      if (own != exp_own) begin
        failures++;
        $display("FAIL rand_owner[%0d]: owner=%0d exp=%0d", r, own, exp_own);
      end
      checks++;
      if (obs_addr !== ea || obs_rnw !== ernw) begin
        failures++;
        $display("FAIL rand_cmd[%0d]: addr=%h rnw=%b exp %h %b", r, obs_addr, obs_rnw, ea, ernw);
      end
      if (!ernw) begin
        checks++;
        if (obs_din !== edin || obs_be !== ebe) begin
          failures++;
          $display("FAIL rand_wdata[%0d]: din=%h be=%b exp %h %b", r, obs_din, obs_be, edin, ebe);
        end
      end
      if (exp_own == 1) m_bg2_dout = d;
      if (exp_own == 2) m_nv_dout = d;
      checks++;
      if (bg2_dout !== m_bg2_dout || nv_dout !== m_nv_dout) begin
        failures++;
        $display("FAIL rand_dout[%0d]: bg2=%h nv=%h exp %h %h", r, bg2_dout, nv_dout, m_bg2_dout, m_nv_dout);
      end
      s = next_starve(exp_own, nr, s);
    end
    rom_req = 0; bg2_req = 0; nv_req = 0; rom_active = 0;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL rand_drain: busy=%b exp=0", busy);
    end
  endtask

  initial begin
    test_reset();
    test_rom_write();
    test_bg2_under_download();
    test_starvation();
    test_dbg_mask();
    test_timeout();
    test_reset_in_wait();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sdr_ch3_arbiter.md
Name: sdr_ch3_arbiter

Overview:
- Shares SDRAM channel 3 between three requesters: the ROM-download writer, the BG2 tile fetcher, and a hiscore/NVRAM read-write port.
- Replaces the static download-mux on ch3 with a sequenced arbiter: one outstanding transaction, fixed priority, a starvation guard for NVRAM, and a watchdog.
- Sits between the rom_loader/XSleenaCore requesters and the sdram controller, in the SDR_CLK domain.

Parameters:
- AW, 24, word address width (16-bit words) presented to ch3.
- NV_STARVE_MAX, 4, consecutive BG2 grants allowed while an NVRAM request waits.
- TIMEOUT, 255, cycles to wait for sdram ready before aborting.

Ports:
- clk  in  1  SDR_CLK.
- reset  in  1  asynchronous, active-high.
- rom_active  in  1  download in progress (ioctl_download && ioctl_index==0).
- rom_req  in  1  level request from ROM writer.
- rom_addr  in  AW  word address.
- rom_din  in  16  write data.
- rom_be  in  2  byte enables.
- rom_rdy  out  1  one-cycle completion pulse.
- bg2_req  in  1  level read request.
- bg2_addr  in  AW  word address.
- bg2_dout  out  16  read data, valid with bg2_rdy.
- bg2_rdy  out  1  completion pulse.
- nv_req  in  1  level request.
- nv_we  in  1  1=write, 0=read.
- nv_addr  in  AW  word address.
- nv_din  in  16  write data.
- nv_be  in  2  byte enables.
- nv_dout  out  16  read data, valid with nv_rdy.
- nv_rdy  out  1  completion pulse.
- dbg_mask  in  1  1 blocks BG2 grants.
- ch3_addr  out  AW  to sdram.
- ch3_din  out  16  to sdram.
- ch3_be  out  2  to sdram.
- ch3_rnw  out  1  1=read.
- ch3_req  out  1  toggle; each edge starts one access.
- ch3_dout  in  16  read data.
- ch3_ready  in  1  one-cycle pulse on completion.
- busy  out  1  transaction outstanding.
- timeout_err  out  1  sticky watchdog flag.

Behaviour:
- Handshake, requester side:
  - The requester holds req high and addr/data stable until its rdy pulse.
  - A requester may drop req only in the cycle after its rdy pulse.
  - Req dropped before grant is ignored. Req dropped after grant does not cancel the access; the rdy pulse is still produced.
- State machine: IDLE, ISSUE, WAIT, DONE.
- IDLE, grant selection:
  - If rom_active: only rom_req is eligible; BG2 and NV are held off.
  - Otherwise: NV wins if nv_req && starve_cnt==NV_STARVE_MAX; else BG2 if bg2_req && !dbg_mask; else NV if nv_req.
  - On grant: latch the owner, address, data, be and rnw into output registers, then go to ISSUE.
  - ROM accesses are always writes with rnw=0.
- ISSUE: toggle ch3_req, clear the watchdog counter, go to WAIT. The ISSUE cycle is exactly one cycle after grant.
- WAIT:
  - On ch3_ready: capture ch3_dout into the owner's dout register and go to DONE.
  - If the counter reaches TIMEOUT: set timeout_err and go to DONE. dout is unchanged and rdy still pulses, so the requester never hangs.
- DONE:
  - Pulse the owner's rdy for one cycle, then return to IDLE.
  - Minimum turnaround is 4 cycles per access; back-to-back grants are permitted from the IDLE cycle that follows.
- starve_cnt (3 bits):
  - Increments on a BG2 grant while nv_req is high.
  - Clears on an NV grant, or when nv_req is low in IDLE.
  - Saturates at NV_STARVE_MAX.
- rom_active rising mid-transaction: the current access completes normally, and no further BG2/NV grants are made.
- A ch3_ready pulse outside WAIT is ignored.
- Reset values:
  - State IDLE; ch3_req=0; ch3_rnw=1.
  - ch3_addr, ch3_din and all dout registers = 0; ch3_be=2'b11.
  - All rdy=0; busy=0; timeout_err=0; starve_cnt=0.
- Reset asserted mid-transaction: return to IDLE immediately. A late ch3_ready is then ignored.
- busy is high in ISSUE, WAIT and DONE.

Decomposition:
- Package sdr_arb_pkg holds:
  - the owner enum (OWN_ROM, OWN_BG2, OWN_NV);
  - the state enum;
  - the NV_STARVE_MAX and TIMEOUT defaults.
- Natural sub-module ch3_watchdog: counter with clear/enable inputs and an expiry output.

Test Plan:
- ROM write: rom_active=1, rom_req with addr 0x000100, din 0xA55A, be 2'b11 → ch3_req toggles 1 cycle after grant with rnw=0; ch3_ready 3 cycles later → rom_rdy pulses exactly once.
- BG2 read under download: rom_active=1, bg2_req=1 → no ch3 toggle for 50 cycles. Drop rom_active → BG2 granted; ch3_dout=0x1234 → bg2_dout=0x1234 with bg2_rdy.
- Starvation guard: bg2_req held high and nv_req high → grant sequence is BG2×4 then NV, and starve_cnt is 0 after the NV grant.
- Debug mask: dbg_mask=1, bg2_req and nv_req both high → NV is granted first; BG2 is never granted while the mask is set.
- Timeout: grant with ch3_ready never asserted → after 255 WAIT cycles timeout_err=1, the owner's rdy pulses, state is IDLE, and the next request proceeds normally.
- Reset in WAIT: assert reset, release, then pulse ch3_ready → no rdy output, busy=0, ch3_req=0.
